// File: rtl/pixel_stream_source_pkg.sv
// Shared definitions for the pixel-stream transmitter: pixel/word sizes,
// default frame geometry, FSM state encoding and a counter-width helper.
package pixel_stream_source_pkg;

  localparam int PIXEL_SIZE       = 24;
  localparam int WORD_SIZE        = 32;
  localparam int DEF_FRAME_WIDTH  = 297;
  localparam int DEF_FRAME_HEIGHT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } pss_state_t;

  // Bits needed to count 0..bound-1, never less than one bit.
  function automatic int cnt_width(input int bound);
    if (bound > 1) begin
      return $clog2(bound);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pixel_stream_source_frame_addr_gen.sv
// Read-pointer and raster position tracker for pixel_stream_source.
// The pointer walks the frame incrementally (base + y*W + x without a
// multiplier) and advances once after every issued memory read, so it always
// holds the address of the next pixel to fetch. x/y follow the pixel shown.
module pixel_stream_source_frame_addr_gen
  import pixel_stream_source_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  ptr_inc,
  input  logic                  pix_adv,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  last_pixel,
  output logic                  penult_pixel,
  output logic                  last_row
);

  localparam int XW = cnt_width(FRAME_WIDTH);
  localparam int YW = cnt_width(FRAME_HEIGHT);

  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;

  assign ptr          = ptr_r;
  assign last_pixel   = (x_r == XW'(FRAME_WIDTH - 1));
  assign penult_pixel = (x_r == XW'(FRAME_WIDTH - 2));
  assign last_row     = (y_r == YW'(FRAME_HEIGHT - 1));

  // Read pointer: reload to the frame base, else step after each read (wraps naturally).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r <= {ADDR_WIDTH{1'b0}};
    end else if (load) begin
      ptr_r <= base;
    end else if (ptr_inc) begin
      ptr_r <= ptr_r + ADDR_WIDTH'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Raster position of the pixel currently on the output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (load) begin
      x_r <= XW'(0);
      y_r <= YW'(0);
    end else if (pix_adv) begin
      if (last_pixel) begin
        x_r <= XW'(0);
        y_r <= last_row ? YW'(0) : (y_r + YW'(1));
      end else begin
        x_r <= x_r + XW'(1);
        y_r <= y_r;
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Transmit side of the pixel-stream interface. Fetches a stored RGB frame
// from a one-cycle-latency frame memory and emits one pixel per clock with
// one-cycle vsync/hsync pulses placed immediately before pixel 0 of a row.
// Every output except data is a register whose value is decided one cycle
// ahead from the next FSM state.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int HBLANK       = 4,
  parameter int VBLANK       = 8,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_rdata,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int BMAX = (VBLANK > HBLANK) ? VBLANK : HBLANK;
  localparam int BW   = cnt_width(BMAX + 1);

  pss_state_t            state_r;
  pss_state_t            nxt_state_s;
  logic [BW-1:0]         blank_cnt_r;
  logic [BW-1:0]         nxt_cnt_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] base_sel_s;
  logic                  en_r;
  logic                  hsync_r;
  logic                  vsync_r;
  logic                  mem_rd_en_r;
  logic                  busy_r;
  logic                  frame_done_r;
  logic [15:0]           frame_cnt_r;
  logic                  last_pixel_s;
  logic                  penult_pixel_s;
  logic                  last_row_s;
  logic                  frame_end_s;
  logic                  accept_s;
  logic                  load_s;
  logic                  vsync_nxt_s;
  logic                  hsync_nxt_s;
  logic                  rd_nxt_s;

  assign accept_s    = (state_r == ST_IDLE) && start;
  assign frame_end_s = (state_r == ST_ACTIVE) && last_pixel_s && last_row_s;
  // Reload at the end of every frame so a continuous restart begins at base.
  assign load_s      = accept_s || frame_end_s;
  assign base_sel_s  = (state_r == ST_IDLE) ? base_addr : base_r;

  pixel_stream_source_frame_addr_gen #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load_s),
    .base         (base_sel_s),
    .ptr_inc      (mem_rd_en_r),
    .pix_adv      (state_r == ST_ACTIVE),
    .ptr          (mem_addr),
    .last_pixel   (last_pixel_s),
    .penult_pixel (penult_pixel_s),
    .last_row     (last_row_s)
  );

  // Next state and blank-counter value; blank counters run from N down to 1.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = blank_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          nxt_state_s = ST_VBLANK;
          nxt_cnt_s   = BW'(VBLANK);
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_VBLANK, ST_HBLANK: begin
        if (blank_cnt_r == BW'(1)) begin
          nxt_state_s = ST_ACTIVE;
        end else begin
          nxt_cnt_s = blank_cnt_r - BW'(1);
        end
      end
      ST_ACTIVE: begin
        if (!last_pixel_s) begin
          nxt_state_s = ST_ACTIVE;
        end else if (!last_row_s) begin
          nxt_state_s = ST_HBLANK;
          nxt_cnt_s   = BW'(HBLANK);
        end else if (continuous) begin
          nxt_state_s = ST_VBLANK;
          nxt_cnt_s   = BW'(VBLANK);
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_cnt_s   = BW'(0);
      end
    endcase
  end

  // Sync pulses mark the last blank cycle; reads run from that cycle up to the penultimate pixel.
  always_comb begin
    vsync_nxt_s = (nxt_state_s == ST_VBLANK) && (nxt_cnt_s == BW'(1));
    hsync_nxt_s = (nxt_state_s == ST_HBLANK) && (nxt_cnt_s == BW'(1));
    if (vsync_nxt_s || hsync_nxt_s) begin
      rd_nxt_s = 1'b1;
    end else if (nxt_state_s == ST_ACTIVE) begin
      rd_nxt_s = !((state_r == ST_ACTIVE) && penult_pixel_s);
    end else begin
      rd_nxt_s = 1'b0;
    end
  end

  // FSM state plus all registered outputs, computed from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      blank_cnt_r  <= BW'(0);
      base_r       <= {ADDR_WIDTH{1'b0}};
      en_r         <= 1'b0;
      hsync_r      <= 1'b0;
      vsync_r      <= 1'b0;
      mem_rd_en_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
    end else begin
      state_r      <= nxt_state_s;
      blank_cnt_r  <= nxt_cnt_s;
      base_r       <= accept_s ? base_addr : base_r;
      en_r         <= (nxt_state_s == ST_ACTIVE);
      hsync_r      <= hsync_nxt_s;
      vsync_r      <= vsync_nxt_s;
      mem_rd_en_r  <= rd_nxt_s;
      busy_r       <= (nxt_state_s != ST_IDLE);
      frame_done_r <= frame_end_s;
      frame_cnt_r  <= frame_end_s ? (frame_cnt_r + 16'd1) : frame_cnt_r;
    end
  end

  assign en         = en_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign mem_rd_en  = mem_rd_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_cnt  = frame_cnt_r;
  // Memory data arrives exactly when the pixel is shown; blank cycles drive zero.
  assign data       = en_r ? mem_rdata : {PIXEL_SIZE{1'b0}};

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source: a small W=4,H=2 instance checked
// cycle by cycle against hand-derived timing, and a full-width W=297,H=3
// instance tracked by a consumer-style x/y model.
module tb_pixel_stream_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, continuous;
  logic [19:0] base_addr;
  logic        mem_rd_en;
  logic [19:0] mem_addr;
  logic [23:0] mem_rdata;
  logic        en, hsync, vsync, busy, frame_done;
  logic [23:0] data;
  logic [15:0] frame_cnt;

  logic        start2;
  logic        mem_rd_en2;
  logic [19:0] mem_addr2;
  logic [23:0] mem_rdata2;
  logic        en2, hsync2, vsync2, busy2, frame_done2;
  logic [23:0] data2;
  logic [15:0] frame_cnt2;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  pixel_stream_source #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .HBLANK(2), .VBLANK(3), .ADDR_WIDTH(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  pixel_stream_source #(
    .FRAME_WIDTH(297), .FRAME_HEIGHT(3), .HBLANK(4), .VBLANK(8), .ADDR_WIDTH(20)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .continuous(1'b0),
    .base_addr(20'h00100), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata2), .en(en2), .hsync(hsync2), .vsync(vsync2), .data(data2),
    .busy(busy2), .frame_done(frame_done2), .frame_cnt(frame_cnt2)
  );

  // Frame memory models: one-cycle read latency, contents equal to the address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {4'h0, mem_addr};
    if (mem_rd_en2) mem_rdata2 <= {4'h0, mem_addr2};
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One W=4,H=2 frame. Cycle k=1 is the first cycle after start is sampled.
  task automatic run_frame(input logic [19:0] base, input bit do_start, input bit cont,
                           input bit restart, input int pulse_k, input int stop_k);
    bit          e_en, e_rd;
    int          pix, rd;
    logic [19:0] ea;
    continuous = cont;
    if (do_start) begin
      start = 1'b1;
      base_addr = base;
      tick();
      start = 1'b0;
      base_addr = 20'h0;
    end
    for (int k = 1; k <= stop_k; k++) begin
      e_en = (k >= 4 && k <= 7) || (k >= 10 && k <= 13);
      e_rd = (k >= 3 && k <= 6) || (k >= 9 && k <= 12);
      pix  = (k <= 7) ? (k - 4) : (k - 6);
      rd   = (k <= 6) ? (k - 3) : (k - 5);
      check_val($sformatf("vsync k=%0d", k), {31'd0, vsync}, {31'd0, (k == 3)});
      check_val($sformatf("hsync k=%0d", k), {31'd0, hsync}, {31'd0, (k == 9)});
      check_val($sformatf("en k=%0d", k), {31'd0, en}, {31'd0, e_en});
      ea = base + 20'(pix);
      check_val($sformatf("data k=%0d", k), {8'd0, data}, e_en ? {12'd0, ea} : 32'd0);
      check_val($sformatf("rd_en k=%0d", k), {31'd0, mem_rd_en}, {31'd0, e_rd});
      if (e_rd) begin
        ea = base + 20'(rd);
        check_val($sformatf("addr k=%0d", k), {12'd0, mem_addr}, {12'd0, ea});
      end
      check_val($sformatf("frame_done k=%0d", k), {31'd0, frame_done},
                {31'd0, (k == 14) || (k == 1 && restart)});
      check_val($sformatf("busy k=%0d", k), {31'd0, busy}, {31'd0, (k < 14) || cont});
      if (k == 14) exp_frames++;
      check_val($sformatf("frame_cnt k=%0d", k), {16'd0, frame_cnt}, 32'(exp_frames & 16'hFFFF));
      start = (k == pulse_k);
      if (k < stop_k) tick();
    end
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " en"}, {31'd0, en}, 32'd0);
    check_val({tag, " vsync"}, {31'd0, vsync}, 32'd0);
    check_val({tag, " hsync"}, {31'd0, hsync}, 32'd0);
    check_val({tag, " rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    check_val({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
    check_val({tag, " data"}, {8'd0, data}, 32'd0);
    check_val({tag, " frame_cnt"}, {16'd0, frame_cnt}, 32'(exp_frames));
  endtask

  initial begin
    int  cx, cy, max_x, npix;
    bit  seen;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; continuous = 1'b0; base_addr = 20'h0;
    repeat (3) tick();
    check_idle("reset");
    check_val("reset addr", {12'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single frame from base 0x10
    run_frame(20'h00010, 1'b1, 1'b0, 1'b0, -1, 14);
    tick();
    check_idle("idle after t1");

    // 2: continuous restart, then stop after the second frame
    run_frame(20'h00010, 1'b1, 1'b1, 1'b0, -1, 14);
    run_frame(20'h00010, 1'b0, 1'b0, 1'b1, -1, 14);
    tick();

    // 3: start pulsed mid-row is ignored
    run_frame(20'h00010, 1'b1, 1'b0, 1'b0, 6, 14);
    tick();

    // 4: reset during row 1 aborts without frame_done, then a clean frame
    run_frame(20'h00010, 1'b1, 1'b0, 1'b0, -1, 11);
    reset_n = 1'b0;
    tick();
    exp_frames = 0;
    check_idle("mid reset");
    check_val("mid reset addr", {12'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;
    tick();
    run_frame(20'h00010, 1'b1, 1'b0, 1'b0, -1, 14);
    tick();

    // 5: address wrap at 2^20
    run_frame(20'hFFFFE, 1'b1, 1'b0, 1'b0, -1, 14);
    tick();

    // 6: full-width frame tracked by a consumer-style x/y model
    cx = 0; cy = 0; max_x = -1; npix = 0; seen = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (vsync2) begin
        cx = 0;
        cy = 0;
      end
      if (hsync2) begin
        cx = 0;
        cy++;
      end
      if (en2) begin
        if (data2 !== 24'(32'h100 + cy * 297 + cx))
          check_val($sformatf("w297 data x=%0d y=%0d", cx, cy), {8'd0, data2},
                    32'h100 + cy * 297 + cx);
        max_x = cx;
        cx++;
        npix++;
      end
      if (frame_done2) seen = 1'b1;
      else tick();
    end
    check_val("w297 frame_done seen", {31'd0, seen}, 32'd1);
    check_val("w297 max x", 32'(max_x), 32'd296);
    check_val("w297 last y", 32'(cy), 32'd2);
    check_val("w297 pixel count", 32'(npix), 32'd891);
    check_val("w297 frame_cnt", {16'd0, frame_cnt2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
